mult_div_sequencer: RTL and testbench

//   Multicycle sequencer for the MULT/DIV resource selected by the ALU control

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_if.sv | 23 ++
 rtl/md_step.sv | 49 ++++
 rtl/mult_div_sequencer.sv | 143 ++++++++++++++
 tb/tb_mult_div_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the MULT/DIV sequencer: FSM states and the
// controlType / StoreMD encodings used by the main control decode.
package md_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_ZERO = 3'd4
  } md_state_e;

  localparam logic [4:0] MD_OP_DIV  = 5'b01001;
  localparam logic [4:0] MD_OP_MULT = 5'b01010;

  localparam logic [1:0] MD_STORE_DIV  = 2'b01;
  localparam logic [1:0] MD_STORE_MULT = 2'b10;

  // StoreMD select for a finished operation
  function automatic logic [1:0] md_store_sel(input logic is_div);
    return is_div ? MD_STORE_DIV : MD_STORE_MULT;
  endfunction

endpackage

// File: rtl/md_if.sv
// Request/result bundle between the main control FSM and the MULT/DIV sequencer.
interface md_if #(parameter int WIDTH = 32);
  logic             start;
  logic             multOp;
  logic             divOp;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, multOp, divOp, a, b,
    input  busy, done, divZero, hi, lo
  );

  modport slave (
    input  start, multOp, divOp, a, b,
    output busy, done, divZero, hi, lo
  );
endinterface

// File: rtl/md_step.sv
// One iteration of the sequencer on the {acc,q} pair: right-shifting
// shift-add for multiply, left-shifting restoring subtract for divide.
module md_step
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_n,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] sh_s;
  logic [WIDTH:0] diff_s;

  // Next {acc,q} for the selected operation
  always_comb begin
    sum_s  = '0;
    sh_s   = '0;
    diff_s = '0;
    acc_n  = acc;
    q_n    = q;
    if (is_div) begin
      sh_s   = {acc[WIDTH-1:0], q[WIDTH-1]};
      diff_s = sh_s - {1'b0, m};
      // Divisor magnitude is at most 2^(WIDTH-1), so diff_s[WIDTH] is a true borrow
      if (diff_s[WIDTH]) begin
        acc_n = sh_s;
        q_n   = {q[WIDTH-2:0], 1'b0};
      end else begin
        acc_n = diff_s;
        q_n   = {q[WIDTH-2:0], 1'b1};
      end
    end else begin
      if (q[0]) begin
        sum_s = acc + {1'b0, m};
      end else begin
        sum_s = acc;
      end
      acc_n = {1'b0, sum_s[WIDTH:1]};
      q_n   = {sum_s[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multicycle signed multiply / divide sequencer writing HI/LO; one iteration
// per clock on operand magnitudes, signs applied in a final FIX cycle.
module mult_div_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH;

  md_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             op_div_r;
  logic             busy_r;
  logic             done_r;
  logic             divzero_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH:0]   acc_n_s;
  logic [WIDTH-1:0] q_n_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [PW-1:0]    prod_mag_s;
  logic [PW-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div (state_r == ST_DIV),
    .acc    (acc_r),
    .q      (q_r),
    .m      (m_r),
    .acc_n  (acc_n_s),
    .q_n    (q_n_s)
  );

  // Operand magnitudes (-2^(WIDTH-1) maps to unsigned 2^(WIDTH-1)) and signed results
  always_comb begin
    a_mag_s    = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    b_mag_s    = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
    prod_mag_s = {acc_r[WIDTH-1:0], q_r};
    prod_s     = neg_q_r ? (~prod_mag_s + PW'(1)) : prod_mag_s;
    quo_s      = neg_q_r ? (~q_r + WIDTH'(1)) : q_r;
    rem_s      = neg_r_r ? (~acc_r[WIDTH-1:0] + WIDTH'(1)) : acc_r[WIDTH-1:0];
  end

  // Sequencer FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      acc_r     <= '0;
      q_r       <= '0;
      m_r       <= '0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      op_div_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start && (bus.multOp ^ bus.divOp)) begin
            acc_r    <= '0;
            cnt_r    <= CNT_W'(WIDTH);
            busy_r   <= 1'b1;
            op_div_r <= bus.divOp;
            neg_q_r  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_r_r  <= bus.a[WIDTH-1];
            if (bus.multOp) begin
              m_r     <= a_mag_s;
              q_r     <= b_mag_s;
              state_r <= ST_MULT;
            end else if (bus.b == '0) begin
              state_r <= ST_ZERO;
            end else begin
              m_r     <= b_mag_s;
              q_r     <= a_mag_s;
              state_r <= ST_DIV;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MULT, ST_DIV: begin
          acc_r <= acc_n_s;
          q_r   <= q_n_s;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r <= ST_FIX;
          end else begin
            state_r <= state_r;
          end
        end
        ST_FIX: begin
          if (md_store_sel(op_div_r) == MD_STORE_DIV) begin
            hi_r <= rem_s;
            lo_r <= quo_s;
          end else begin
            hi_r <= prod_s[PW-1:WIDTH];
            lo_r <= prod_s[WIDTH-1:0];
          end
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_ZERO: begin
          done_r    <= 1'b1;
          divzero_r <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.divZero = divzero_r;
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed vector table, hand-written
// handshake/reset sequences and random operations against an arithmetic model.
module tb_mult_div_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  md_if #(.WIDTH(32)) bus ();

  mult_div_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: exact signed arithmetic; divide by zero leaves hi/lo alone
  task automatic ref_model(input bit is_mult, input logic [31:0] av, input logic [31:0] bv,
                           inout logic [31:0] h, inout logic [31:0] l, output bit dz);
    longint p;
    int     sa;
    int     sb;
    sa = av;
    sb = bv;
    dz = 1'b0;
    if (is_mult) begin
      p = longint'(sa) * longint'(sb);
      h = p[63:32];
      l = p[31:0];
    end else if (sb == 0) begin
      dz = 1'b1;
    end else if (sa == 32'sh80000000 && sb == -1) begin
      h = 32'h0;
      l = 32'h80000000;
    end else begin
      h = sa % sb;
      l = sa / sb;
    end
  endtask

  // Launch at the current (post-edge) time, wait for done; optional stray start at edge glitch_at
  task automatic run_op(input bit is_mult, input logic [31:0] av, input logic [31:0] bv,
                        input int glitch_at, output int lat, output bit busy_ok);
    bus.start  = 1'b1;
    bus.multOp = is_mult;
    bus.divOp  = !is_mult;
    bus.a      = av;
    bus.b      = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat       = 0;
    busy_ok   = bus.busy;
    for (int n = 1; n <= 40; n++) begin
      if (n == glitch_at) begin
        bus.start  = 1'b1;
        bus.multOp = 1'b0;
        bus.divOp  = 1'b1;
        bus.b      = 32'h0;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic op_check(input string tag, input bit is_mult, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                          input bit edz, input int glitch_at);
    int lat;
    bit busy_ok;
    run_op(is_mult, av, bv, glitch_at, lat, busy_ok);
    chk({tag, ".latency"}, 32'(lat), edz ? 32'd1 : 32'd33);
    chk({tag, ".busy_during"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, ".busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, ".divZero"}, {31'd0, bus.divZero}, {31'd0, edz});
    chk({tag, ".hi"}, bus.hi, eh);
    chk({tag, ".lo"}, bus.lo, el);
  endtask

  task automatic model_op(input string tag, input bit is_mult, input logic [31:0] av,
                          input logic [31:0] bv, input int glitch_at);
    bit dz;
    ref_model(is_mult, av, bv, m_hi, m_lo, dz);
    op_check(tag, is_mult, av, bv, m_hi, m_lo, dz, glitch_at);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    m_hi       = 32'h0;
    m_lo       = 32'h0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.multOp = 1'b0;
    bus.divOp  = 1'b0;
    bus.a      = 32'h0;
    bus.b      = 32'h0;

    tbl[0] = '{1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[1] = '{1'b0, 32'd100,      32'd7,        32'd2,        32'd14};
    tbl[2] = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[4] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    tbl[6] = '{1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    tbl[7] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    tbl[8] = '{1'b0, 32'd0,        32'd5,        32'd0,        32'd0};
    tbl[9] = '{1'b1, 32'h12345678, 32'd0,        32'd0,        32'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", {31'd0, bus.busy}, 32'd0);
    chk("reset.done", {31'd0, bus.done}, 32'd0);
    chk("reset.divZero", {31'd0, bus.divZero}, 32'd0);
    chk("reset.hi", bus.hi, 32'd0);
    chk("reset.lo", bus.lo, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed table; each op starts in the previous op's done cycle
    for (int i = 0; i < 10; i++) begin
      op_check($sformatf("tbl%0d", i), tbl[i].is_mult, tbl[i].a, tbl[i].b,
               tbl[i].hi, tbl[i].lo, 1'b0, 0);
      m_hi = tbl[i].hi;
      m_lo = tbl[i].lo;
    end

    // Divide by zero keeps the preloaded hi/lo
    op_check("preload", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
    op_check("divzero", 1'b0, 32'd5, 32'd0, 32'd2, 32'd14, 1'b1, 0);
    @(posedge clk);
    #1;
    chk("divzero.done_clear", {31'd0, bus.done}, 32'd0);
    chk("divzero.flag_clear", {31'd0, bus.divZero}, 32'd0);

    // Stray start during iteration 5 must not disturb the running multiply
    op_check("busy_start", 1'b1, 32'd1000, 32'hFFFFFF9C, 32'hFFFFFFFF, 32'hFFFE7960, 1'b0, 5);
    m_hi = 32'hFFFFFFFF;
    m_lo = 32'hFFFE7960;

    // Start with both or neither op bit is ignored
    for (int k = 0; k < 2; k++) begin
      bus.start  = 1'b1;
      bus.multOp = (k == 0);
      bus.divOp  = (k == 0);
      bus.a      = 32'd9;
      bus.b      = 32'd0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) begin
        chk($sformatf("badop%0d.busy", k), {31'd0, bus.busy}, 32'd0);
        chk($sformatf("badop%0d.done", k), {31'd0, bus.done}, 32'd0);
        @(posedge clk);
        #1;
      end
      chk($sformatf("badop%0d.hi", k), bus.hi, 32'hFFFFFFFF);
    end

    // Reset in the middle of iteration 10 clears outputs without a clock edge
    bus.start  = 1'b1;
    bus.multOp = 1'b1;
    bus.divOp  = 1'b0;
    bus.a      = 32'd7;
    bus.b      = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset.busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset.done", {31'd0, bus.done}, 32'd0);
    chk("midreset.hi", bus.hi, 32'd0);
    chk("midreset.lo", bus.lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi  = 32'h0;
    m_lo  = 32'h0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) break;
    end
    chk("midreset.no_done", {31'd0, bus.done}, 32'd0);
    model_op("post_reset", 1'b1, 32'd3, 32'd4, 0);

    // Random operations against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      bit          is_mult;
      logic [31:0] av;
      logic [31:0] bv;
      is_mult = $urandom_range(1, 0) == 1;
      av      = $urandom;
      bv      = $urandom;
      case ($urandom_range(7, 0))
        0: av = 32'h80000000;
        1: bv = is_mult ? 32'h80000000 : 32'd0;
        2: bv = 32'hFFFFFFFF;
        3: bv = 32'($urandom_range(20, 1));
        default: av = av;
      endcase
      model_op($sformatf("rnd%0d", i), is_mult, av, bv, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
